// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder scheduler.
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice; exposes the carry into bit 3 so the
// caller can form signed overflow on the most significant nibble.
module nibble_add
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] s_o,
  output logic             cout_o,
  output logic             c3_o
);

  logic [3:0] low_sum;
  logic [1:0] top_sum;

  // Bits 2:0 first, then bit 3 on its own so its carry-in is visible.
  assign low_sum = {1'b0, a_i[2:0]} + {1'b0, b_i[2:0]} + {3'b000, cin_i};
  assign c3_o    = low_sum[3];
  assign top_sum = {1'b0, a_i[3]} + {1'b0, b_i[3]} + {1'b0, c3_o};
  assign s_o     = {top_sum[0], low_sum[2:0]};
  assign cout_o  = top_sum[1];

endmodule

// File: rtl/nibble_add_sched.sv
// Round-robin scheduler sharing one nibble adder between two requesters;
// each WIDTH-bit add is walked LSB nibble first, one nibble per cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. reqX_ready is a combinational function of the valid inputs and
// the arbiter pointer; valid must never wait on ready. rsp_* is held stable
// while rsp_valid is high and rsp_ready is low.
module nibble_add_sched
  import nibble_add_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / NIB_W
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,

  output state_t           dbg_state_o
);

  localparam int                IDX_W    = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NIB - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  req_id_t            last_q, last_d;
  req_id_t            id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic               grant0, grant1, accept;
  req_id_t            win_id;
  logic [NIB_W-1:0]   nib_a, nib_b, nib_s;
  logic               nib_cout, nib_c3;
  logic               last_nib;

  // The requester that did not win last time has priority on contention.
  assign grant0 = req0_valid && (!req1_valid || (last_q == 1'b1));
  assign grant1 = req1_valid && (!req0_valid || (last_q == 1'b0));
  assign accept = (state_q == IDLE) && (grant0 || grant1);
  assign win_id = grant0 ? 1'b0 : 1'b1;

  assign last_nib = (idx_q == IDX_LAST);
  assign nib_a    = a_q[idx_q*NIB_W +: NIB_W];
  assign nib_b    = b_q[idx_q*NIB_W +: NIB_W];

  nibble_add u_nibble_add (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (carry_q),
    .s_o    (nib_s),
    .cout_o (nib_cout),
    .c3_o   (nib_c3)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_nib)  state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM outputs; response fields read as zero outside DONE.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_sum    = '0;
    rsp_cout   = 1'b0;
    rsp_ovf    = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_sum   = sum_q;
        rsp_cout  = carry_q;
        rsp_ovf   = ovf_q;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

  // Operand capture and nibble walk
  always_comb begin
    idx_d   = idx_q;
    last_d  = last_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (accept) begin
      idx_d   = '0;
      last_d  = win_id;
      id_d    = win_id;
      a_d     = grant0 ? req0_a   : req1_a;
      b_d     = grant0 ? req0_b   : req1_b;
      carry_d = grant0 ? req0_cin : req1_cin;
      sum_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == RUN) begin
      sum_d[idx_q*NIB_W +: NIB_W] = nib_s;
      carry_d = nib_cout;
      if (last_nib) begin
        ovf_d = nib_c3 ^ nib_cout;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
